// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle MIPS control FSM and its datapath.
// The FSM side uses the master modport; the datapath side uses slave.
interface mc_ctrl_fsm_if;
  logic [5:0] opcode;
  logic       mem_ack;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_timeout;
  logic [3:0] state_o;

  modport master (
    input  opcode, mem_ack,
    output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, mem_timeout, state_o
  );

  modport slave (
    output opcode, mem_ack,
    input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
           ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal_op, mem_timeout, state_o
  );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared datapath, with optional memory handshake and ack timeout.
module mc_ctrl_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int ACK_TIMEOUT   = 0
) (
  input logic          clk,
  input logic          rst,
  mc_ctrl_fsm_if.master bus
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] FETCH    = 4'd1;
  localparam logic [3:0] DECODE   = 4'd2;
  localparam logic [3:0] MEM_ADDR = 4'd3;
  localparam logic [3:0] MEM_RD   = 4'd4;
  localparam logic [3:0] MEM_WB   = 4'd5;
  localparam logic [3:0] MEM_WR   = 4'd6;
  localparam logic [3:0] R_EXEC   = 4'd7;
  localparam logic [3:0] R_WB     = 4'd8;
  localparam logic [3:0] BRANCH   = 4'd9;
  localparam logic [3:0] JUMP     = 4'd10;
  localparam logic [3:0] I_EXEC   = 4'd11;
  localparam logic [3:0] I_WB     = 4'd12;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam bit         TIMEOUT_EN   = (ACK_TIMEOUT > 0);
  localparam logic [15:0] TIMEOUT_LAST = 16'(ACK_TIMEOUT - 1);

  logic [3:0]  state;
  logic [3:0]  nextState;
  logic [15:0] waitCnt;
  logic        advance;
  logic        inMemState;
  logic        timeoutHit;

  // The expiry cycle is the last permitted wait cycle; an ack arriving in it still wins.
  assign advance    = ~MEM_HANDSHAKE | bus.mem_ack;
  assign inMemState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  assign timeoutHit = TIMEOUT_EN && inMemState && !advance && (waitCnt == TIMEOUT_LAST);

  always_comb begin
    nextState = state;
    case (state)
      IDLE:     nextState = FETCH;
      FETCH:    if (advance) nextState = DECODE;
                else if (timeoutHit) nextState = IDLE;
      DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     nextState = R_EXEC;
          OP_LW, OP_SW: nextState = MEM_ADDR;
          OP_BEQ:       nextState = BRANCH;
          OP_J:         nextState = JUMP;
          OP_ADDI:      nextState = I_EXEC;
          default:      nextState = FETCH;
        endcase
      end
      MEM_ADDR: nextState = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD:   if (advance) nextState = MEM_WB;
                else if (timeoutHit) nextState = IDLE;
      MEM_WR:   if (advance) nextState = FETCH;
                else if (timeoutHit) nextState = IDLE;
      R_EXEC:   nextState = R_WB;
      I_EXEC:   nextState = I_WB;
      MEM_WB, R_WB, BRANCH, JUMP, I_WB: nextState = FETCH;
      default:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state <= nextState;
      if (inMemState && !advance && !timeoutHit) waitCnt <= waitCnt + 16'd1;
      else waitCnt <= '0;
    end
  end

  logic       pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite;
  logic       regDst, memToReg, regWrite, aluSrcA, instrDone, illegalOp;
  logic [1:0] pcSource, aluSrcB, aluOp;

  always_comb begin
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    pcSource    = 2'b00;
    iOrD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    regDst      = 1'b0;
    memToReg    = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    instrDone   = 1'b0;
    illegalOp   = 1'b0;
    case (state)
      FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        irWrite = advance;
        pcWrite = advance;
      end
      DECODE: begin
        aluSrcB = 2'b11;
        case (bus.opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: illegalOp = 1'b0;
          default: begin
            illegalOp = 1'b1;
            instrDone = 1'b1;
          end
        endcase
      end
      MEM_ADDR, I_EXEC: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      MEM_RD: begin
        memRead = 1'b1;
        iOrD    = 1'b1;
      end
      MEM_WB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        instrDone = 1'b1;
      end
      MEM_WR: begin
        memWrite  = 1'b1;
        iOrD      = 1'b1;
        instrDone = advance;
      end
      R_EXEC: begin
        aluSrcA = 1'b1;
        aluOp   = 2'b10;
      end
      R_WB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        instrDone = 1'b1;
      end
      BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        instrDone   = 1'b1;
      end
      JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        instrDone = 1'b1;
      end
      I_WB: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.pc_write      = pcWrite;
  assign bus.pc_write_cond = pcWriteCond;
  assign bus.pc_source     = pcSource;
  assign bus.i_or_d        = iOrD;
  assign bus.mem_read      = memRead;
  assign bus.mem_write     = memWrite;
  assign bus.ir_write      = irWrite;
  assign bus.reg_dst       = regDst;
  assign bus.mem_to_reg    = memToReg;
  assign bus.reg_write     = regWrite;
  assign bus.alu_src_a     = aluSrcA;
  assign bus.alu_src_b     = aluSrcB;
  assign bus.alu_op        = aluOp;
  assign bus.instr_done    = instrDone;
  assign bus.illegal_op    = illegalOp;
  assign bus.mem_timeout   = timeoutHit;
  assign bus.state_o       = state;

endmodule
